// File: rtl/fpu_issue_ctrl.sv
// FP issue/hazard controller: scoreboard, writeback reservation table, div/sqrt serialisation.
// Optional macro FPU_ISSUE_FLUSH_EN adds a flush input that squashes all in-flight state.
module fpu_issue_ctrl #(
    parameter int NUM_FREGS = 32,
    parameter int REG_AW    = 5,
    parameter int LAT_ADD   = 3,
    parameter int LAT_MUL   = 4,
    parameter int LAT_DIV   = 12,
    parameter int LAT_SQRT  = 16,
    localparam int M1       = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL,
    localparam int M2       = (LAT_DIV > LAT_SQRT) ? LAT_DIV : LAT_SQRT,
    localparam int MAX_LAT  = (M1 > M2) ? M1 : M2,
    localparam int CW       = $clog2(MAX_LAT + 1)
) (
    input  logic              clk,
    input  logic              rst,
`ifdef FPU_ISSUE_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              id_valid,
    input  logic [2:0]        id_op,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    output logic              id_ready,
    output logic              fu_start,
    output logic [2:0]        fu_op,
    output logic [REG_AW-1:0] fu_rd,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_rd,
    output logic              divsqrt_busy,
    output logic              illegal_op,
    output logic [CW-1:0]     inflight_cnt
);

    // Stage 0 of the table is the registered writeback slot.
    logic                 tv  [MAX_LAT];
    logic [REG_AW-1:0]    trd [MAX_LAT];
    logic [NUM_FREGS-1:0] sb;
    logic [NUM_FREGS-1:0] sb_set;
    logic [NUM_FREGS-1:0] sb_clr;
    logic [CW-1:0]        div_cnt;
    logic [CW-1:0]        lat;
    logic                 legal;
    logic                 is_div;
    logic                 kill;
    logic                 slot_free;
    logic                 rs1_busy;
    logic                 rs2_busy;
    logic                 rd_busy;
    logic                 div_ok;
    logic                 checks_ok;

`ifdef FPU_ISSUE_FLUSH_EN
    assign kill     = rst | flush;
    assign wb_valid = tv[0] & ~flush;
`else
    assign kill     = rst;
    assign wb_valid = tv[0];
`endif

    assign wb_rd        = trd[0];
    assign legal        = (id_op <= 3'd4);
    assign is_div       = (id_op == 3'd3) || (id_op == 3'd4);
    assign divsqrt_busy = (div_cnt != '0);
    assign fu_op        = id_op;
    assign fu_rd        = id_rd;

    // Per-op latency selection.
    always_comb begin
        lat = CW'(LAT_ADD);
        unique case (id_op)
            3'd2:    lat = CW'(LAT_MUL);
            3'd3:    lat = CW'(LAT_DIV);
            3'd4:    lat = CW'(LAT_SQRT);
            default: lat = CW'(LAT_ADD);
        endcase
    end

    // Stage currently at index lat moves to lat-1 and must be empty.
    always_comb begin
        slot_free = 1'b1;
        for (int i = 1; i < MAX_LAT; i++) begin
            if (lat == CW'(i) && tv[i]) slot_free = 1'b0;
        end
    end

    // Scoreboard hazards with write-through bypass of the current writeback.
    assign rs1_busy = sb[id_rs1] && !(tv[0] && trd[0] == id_rs1);
    assign rs2_busy = sb[id_rs2] && !(tv[0] && trd[0] == id_rs2);
    assign rd_busy  = sb[id_rd]  && !(tv[0] && trd[0] == id_rd);

    // The iterative unit can take a new op in its predecessor's final cycle.
    assign div_ok    = !is_div || (div_cnt <= CW'(1));
    assign checks_ok = !rs1_busy && (id_op == 3'd4 || !rs2_busy) &&
                       !rd_busy && slot_free && div_ok;

    assign id_ready   = id_valid && !kill && (!legal || checks_ok);
    assign fu_start   = id_ready && legal;
    assign illegal_op = id_ready && !legal;

    // Scoreboard set/clear masks.
    always_comb begin
        sb_set = '0;
        sb_clr = '0;
        if (fu_start) sb_set[id_rd] = 1'b1;
        if (tv[0])    sb_clr[trd[0]] = 1'b1;
    end

    // Table shift/insert, scoreboard, div counter and inflight count.
    always_ff @(posedge clk) begin
        if (kill) begin
            for (int i = 0; i < MAX_LAT; i++) begin
                tv[i]  <= 1'b0;
                trd[i] <= '0;
            end
            sb           <= '0;
            div_cnt      <= '0;
            inflight_cnt <= '0;
        end else begin
            for (int i = 0; i < MAX_LAT - 1; i++) begin
                tv[i]  <= tv[i+1];
                trd[i] <= trd[i+1];
            end
            tv[MAX_LAT-1]  <= 1'b0;
            trd[MAX_LAT-1] <= '0;
            if (fu_start) begin
                for (int i = 0; i < MAX_LAT; i++) begin
                    if (lat == CW'(i + 1)) begin
                        tv[i]  <= 1'b1;
                        trd[i] <= id_rd;
                    end
                end
            end
            sb <= (sb & ~sb_clr) | sb_set;
            if (fu_start && is_div) div_cnt <= lat;
            else if (div_cnt != '0) div_cnt <= div_cnt - CW'(1);
            if (fu_start && !tv[0]) inflight_cnt <= inflight_cnt + CW'(1);
            else if (!fu_start && tv[0]) inflight_cnt <= inflight_cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: directed scenarios then random traffic,
// checked each cycle against a time-stamped model of pending writebacks.
module tb_fpu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [2:0] id_op;
    logic [4:0] id_rd, id_rs1, id_rs2;
    logic       id_ready, fu_start, wb_valid, divsqrt_busy, illegal_op;
    logic [2:0] fu_op;
    logic [4:0] fu_rd, wb_rd;
    logic [4:0] inflight_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pt[$];
    int prd[$];
    int div_start = -1000;
    int div_end   = -1000;

    fpu_issue_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op),
        .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_ready(id_ready), .fu_start(fu_start), .fu_op(fu_op),
        .fu_rd(fu_rd), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .divsqrt_busy(divsqrt_busy), .illegal_op(illegal_op),
        .inflight_cnt(inflight_cnt)
    );

    always #5 clk = ~clk;

    function automatic int latf(input int op);
        case (op)
            2: return 4;
            3: return 12;
            4: return 16;
            default: return 3;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d",
                   tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input int op,
                        input int rd, input int rs1, input int rs2);
        int  l, infl, ewbrd;
        bit  ewb, b1, b2, bd, slot, divb, divok, legal, rdy;
        @(posedge clk);
        #1;
        rst = r; id_valid = v; id_op = 3'(op);
        id_rd = 5'(rd); id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
        @(negedge clk);
        l = latf(op); legal = (op < 5);
        ewb = 0; ewbrd = 0; infl = 0;
        b1 = 0; b2 = 0; bd = 0; slot = 1;
        foreach (pt[i]) begin
            if (pt[i] == cyc) begin ewb = 1; ewbrd = prd[i]; end
            if (pt[i] >= cyc) infl++;
            if (pt[i] > cyc) begin
                if (prd[i] == rs1) b1 = 1;
                if (prd[i] == rs2) b2 = 1;
                if (prd[i] == rd)  bd = 1;
            end
            if (pt[i] == cyc + l) slot = 0;
        end
        divb  = (cyc > div_start) && (cyc <= div_end);
        divok = (op != 3 && op != 4) || (cyc >= div_end);
        rdy = v && !r && (!legal ||
              (!b1 && (op == 4 || !b2) && !bd && slot && divok));
        chk("id_ready", 32'(id_ready), 32'(rdy));
        chk("fu_start", 32'(fu_start), 32'(rdy && legal));
        chk("illegal_op", 32'(illegal_op), 32'(rdy && !legal));
        chk("wb_valid", 32'(wb_valid), 32'(ewb));
        if (ewb) chk("wb_rd", 32'(wb_rd), 32'(ewbrd));
        chk("divsqrt_busy", 32'(divsqrt_busy), 32'(divb));
        chk("inflight_cnt", 32'(inflight_cnt), 32'(infl));
        if (rdy && legal) begin
            chk("fu_op", 32'(fu_op), 32'(op));
            chk("fu_rd", 32'(fu_rd), 32'(rd));
        end
        if (r) begin
            pt.delete(); prd.delete();
            div_start = -1000; div_end = -1000;
        end else if (rdy && legal) begin
            pt.push_back(cyc + l); prd.push_back(rd);
            if (op == 3 || op == 4) begin
                div_start = cyc; div_end = cyc + l;
            end
        end
        for (int i = pt.size() - 1; i >= 0; i--) begin
            if (pt[i] <= cyc) begin pt.delete(i); prd.delete(i); end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0, 0);
    endtask

    initial begin
        int op;
        rst = 1'b1; id_valid = 1'b0; id_op = '0;
        id_rd = '0; id_rs1 = '0; id_rs2 = '0;
        repeat (2) @(posedge clk);
        // reset state
        step(1'b1, 1'b1, 0, 1, 0, 0);
        // single FADD
        step(1'b0, 1'b1, 0, 1, 0, 0);
        idle(5);
        // RAW with bypass
        step(1'b0, 1'b1, 0, 1, 0, 0);
        repeat (3) step(1'b0, 1'b1, 2, 2, 1, 0);
        idle(6);
        // writeback slot collision
        step(1'b0, 1'b1, 2, 3, 0, 0);
        repeat (2) step(1'b0, 1'b1, 0, 4, 0, 0);
        idle(5);
        // div then sqrt serialised
        step(1'b0, 1'b1, 3, 5, 0, 0);
        repeat (12) step(1'b0, 1'b1, 4, 6, 7, 0);
        idle(17);
        // illegal op with busy rd
        step(1'b0, 1'b1, 0, 1, 0, 0);
        step(1'b0, 1'b1, 6, 1, 1, 1);
        idle(4);
        // reset kills in-flight div
        step(1'b0, 1'b1, 3, 8, 0, 0);
        idle(1);
        step(1'b1, 1'b0, 0, 0, 0, 0);
        step(1'b0, 1'b1, 3, 8, 0, 0);
        idle(14);
        // random traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom % 16 == 0) op = 5 + int'($urandom % 3);
            else op = int'($urandom % 5);
            step(($urandom % 300) == 0, ($urandom % 4) != 0, op,
                 int'($urandom % 8), int'($urandom % 8), int'($urandom % 8));
        end
        idle(20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
